// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, issues one instruction-memory read per
// instruction, and computes the next PC once branch resolution has been gathered.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Controller_branch,
    input  logic        Controller_branch_kick_up,
    input  logic        ALU_Zero,
    input  logic        ALU_Zero_kick_up,
    input  logic [31:0] imme,
    input  logic        imme_kick_up,
    output logic        instruction_kick_up,
    output logic        inst_mem_read_enable,
    output logic [31:0] inst_mem_read_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DELIVER,
        S_RESOLVE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rd_en_q, rd_en_d;
    logic        kick_q, kick_d;
    logic        have_br_q, have_br_d;
    logic        have_z_q, have_z_d;
    logic        have_imm_q, have_imm_d;
    logic        br_q, br_d;
    logic        z_q, z_d;
    logic [31:0] imm_q, imm_d;

    logic        eff_have_br, eff_have_z, eff_have_imm;
    logic        eff_br, eff_z;
    logic [31:0] eff_imm;
    logic        resolve;

    // A strobe in the current cycle takes precedence over the latched copy.
    always_comb begin
        eff_have_br  = have_br_q | Controller_branch_kick_up;
        eff_have_z   = have_z_q | ALU_Zero_kick_up;
        eff_have_imm = have_imm_q | imme_kick_up;
        eff_br       = Controller_branch_kick_up ? Controller_branch : br_q;
        eff_z        = ALU_Zero_kick_up ? ALU_Zero : z_q;
        eff_imm      = imme_kick_up ? imme : imm_q;
        resolve      = (state_q == S_RESOLVE) && eff_have_br &&
                       (!eff_br || (eff_have_z && eff_have_imm));
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        have_br_d  = eff_have_br;
        have_z_d   = eff_have_z;
        have_imm_d = eff_have_imm;
        br_d       = eff_br;
        z_d        = eff_z;
        imm_d      = eff_imm;

        case (state_q)
            S_IDLE:    state_d = S_ISSUE;
            S_ISSUE:   state_d = S_DELIVER;
            S_DELIVER: state_d = S_RESOLVE;
            S_RESOLVE: begin
                if (resolve) begin
                    // Resolving strobes are consumed here and never carry over.
                    pc_d       = (eff_br && eff_z) ? pc_q + eff_imm : pc_q + PC_STEP;
                    state_d    = S_ISSUE;
                    have_br_d  = 1'b0;
                    have_z_d   = 1'b0;
                    have_imm_d = 1'b0;
                    br_d       = 1'b0;
                    z_d        = 1'b0;
                    imm_d      = 32'h0;
                end
            end
            default:   state_d = S_IDLE;
        endcase

        rd_en_d = (state_d == S_ISSUE);
        kick_d  = (state_d == S_DELIVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            rd_en_q    <= 1'b0;
            kick_q     <= 1'b0;
            have_br_q  <= 1'b0;
            have_z_q   <= 1'b0;
            have_imm_q <= 1'b0;
            br_q       <= 1'b0;
            z_q        <= 1'b0;
            imm_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_en_q    <= rd_en_d;
            kick_q     <= kick_d;
            have_br_q  <= have_br_d;
            have_z_q   <= have_z_d;
            have_imm_q <= have_imm_d;
            br_q       <= br_d;
            z_q        <= z_d;
            imm_q      <= imm_d;
        end
    end

    assign inst_mem_read_enable = rd_en_q;
    assign instruction_kick_up  = kick_q;
    assign inst_mem_read_addr   = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table of fetch/branch vectors plus hand-written sequences,
// with fetch addresses and fetch periods checked through a scoreboard queue.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Controller_branch = 1'b0;
    logic        Controller_branch_kick_up = 1'b0;
    logic        ALU_Zero = 1'b0;
    logic        ALU_Zero_kick_up = 1'b0;
    logic [31:0] imme = 32'h0;
    logic        imme_kick_up = 1'b0;
    logic        instruction_kick_up;
    logic        inst_mem_read_enable;
    logic [31:0] inst_mem_read_addr;

    if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .Controller_branch         (Controller_branch),
        .Controller_branch_kick_up (Controller_branch_kick_up),
        .ALU_Zero                  (ALU_Zero),
        .ALU_Zero_kick_up          (ALU_Zero_kick_up),
        .imme                      (imme),
        .imme_kick_up              (imme_kick_up),
        .instruction_kick_up       (instruction_kick_up),
        .inst_mem_read_enable      (inst_mem_read_enable),
        .inst_mem_read_addr        (inst_mem_read_addr)
    );

    always #5 clk = ~clk;

    // mode 0: all strobes in first RESOLVE cycle; 1: all strobes in DELIVER;
    // 2: branch, imme two cycles later, then zero; 3: branch strobe only
    typedef struct {
        logic        br;
        logic        z;
        logic [31:0] imm;
        int          mode;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          gap;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_issue = -1;
    logic prev_rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: checks kick follows each read and pops the scoreboard on each fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_rd    = 1'b0;
                last_issue = -1;
            end else begin
                chk("kick_follows_read", 32'(instruction_kick_up), 32'(prev_rd));
                if (inst_mem_read_enable) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch: addr %h, no fetch expected (t=%0t)",
                                 inst_mem_read_addr, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("fetch_addr", inst_mem_read_addr, e.addr);
                        if (e.gap >= 0 && last_issue >= 0)
                            chk("fetch_period", 32'(cyc - last_issue), 32'(e.gap));
                    end
                    last_issue = cyc;
                end
                prev_rd = inst_mem_read_enable;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_in();
        Controller_branch         = 1'b0;
        Controller_branch_kick_up = 1'b0;
        ALU_Zero                  = 1'b0;
        ALU_Zero_kick_up          = 1'b0;
        imme                      = 32'h0;
        imme_kick_up              = 1'b0;
    endtask

    task automatic drive_br(input logic b);
        Controller_branch         = b;
        Controller_branch_kick_up = 1'b1;
    endtask

    task automatic drive_z(input logic z);
        ALU_Zero         = z;
        ALU_Zero_kick_up = 1'b1;
    endtask

    task automatic drive_imm(input logic [31:0] v);
        imme         = v;
        imme_kick_up = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] a, input int gap);
        exp_t e;
        e.addr = a;
        e.gap  = gap;
        sbq.push_back(e);
    endtask

    // Leaves the bench at the negedge of the next ISSUE cycle.
    task automatic wait_issue();
        int n = 0;
        while (!inst_mem_read_enable && n < 20) begin
            step();
            n++;
        end
        if (!inst_mem_read_enable) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: no fetch within 20 cycles (t=%0t)", $time);
        end
    endtask

    task automatic stall_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(name, 32'(inst_mem_read_enable), 32'd0);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        push_exp(v.exp_addr, (v.mode == 2) ? 6 : 3);
        case (v.mode)
            1: begin
                step();
                drive_br(v.br); drive_z(v.z); drive_imm(v.imm);
                step();
                clear_in();
            end
            0: begin
                step(); step();
                drive_br(v.br); drive_z(v.z); drive_imm(v.imm);
                step();
                clear_in();
            end
            2: begin
                step(); step();
                drive_br(v.br);
                step(); clear_in();
                step();
                drive_imm(v.imm);
                step(); clear_in();
                drive_z(v.z);
                step(); clear_in();
            end
            default: begin
                step(); step();
                drive_br(v.br);
                step(); clear_in();
            end
        endcase
        wait_issue();
    endtask

    initial begin
        vecs[0]  = '{br: 1'b0, z: 1'b0, imm: 32'h0,         mode: 3, exp_addr: 32'h0000_0004};
        vecs[1]  = '{br: 1'b0, z: 1'b0, imm: 32'h0,         mode: 3, exp_addr: 32'h0000_0008};
        vecs[2]  = '{br: 1'b1, z: 1'b1, imm: 32'h10,        mode: 2, exp_addr: 32'h0000_0018};
        vecs[3]  = '{br: 1'b1, z: 1'b0, imm: 32'h10,        mode: 0, exp_addr: 32'h0000_001C};
        vecs[4]  = '{br: 1'b0, z: 1'b1, imm: 32'h100,       mode: 0, exp_addr: 32'h0000_0020};
        vecs[5]  = '{br: 1'b1, z: 1'b1, imm: 32'hFFFF_FFF0, mode: 0, exp_addr: 32'h0000_0010};
        vecs[6]  = '{br: 1'b1, z: 1'b1, imm: 32'h4,         mode: 1, exp_addr: 32'h0000_0014};
        vecs[7]  = '{br: 1'b1, z: 1'b1, imm: 32'hFFFF_FFE8, mode: 1, exp_addr: 32'hFFFF_FFFC};
        vecs[8]  = '{br: 1'b0, z: 1'b0, imm: 32'h0,         mode: 3, exp_addr: 32'h0000_0000};
        vecs[9]  = '{br: 1'b1, z: 1'b1, imm: 32'h4,         mode: 1, exp_addr: 32'h0000_0004};
        vecs[10] = '{br: 1'b1, z: 1'b1, imm: 32'h4,         mode: 0, exp_addr: 32'h0000_0008};
        vecs[11] = '{br: 1'b1, z: 1'b0, imm: 32'h10,        mode: 2, exp_addr: 32'h0000_000C};

        // Reset state, first fetch, then an indefinite stall with no strobes
        step(); step();
        chk("reset_read_en", 32'(inst_mem_read_enable), 32'd0);
        chk("reset_kick", 32'(instruction_kick_up), 32'd0);
        chk("reset_addr", inst_mem_read_addr, 32'h0);
        push_exp(32'h0, -1);
        reset = 1'b0;
        wait_issue();
        step();
        chk("deliver_kick", 32'(instruction_kick_up), 32'd1);
        chk("deliver_read_en", 32'(inst_mem_read_enable), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_read_en", 32'(inst_mem_read_enable), 32'd0);
            chk("stall_kick", 32'(instruction_kick_up), 32'd0);
            chk("stall_addr", inst_mem_read_addr, 32'h0);
        end

        reset = 1'b1;
        step();
        push_exp(32'h0, -1);
        reset = 1'b0;
        wait_issue();

        for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

        // Strobes consumed by a resolution must not satisfy the next instruction
        step(); step();
        push_exp(32'h14, 3);
        drive_br(1'b1); drive_z(1'b1); drive_imm(32'h8);
        step(); clear_in();
        wait_issue();
        step(); step();
        drive_br(1'b1);
        step(); clear_in();
        stall_check("no_reuse_stall", 8);
        push_exp(32'h34, -1);
        drive_z(1'b1); drive_imm(32'h20);
        step(); clear_in();
        wait_issue();

        // Asynchronous reset in RESOLVE with latched branch and imme
        step(); step();
        drive_br(1'b1); drive_imm(32'h40);
        step(); clear_in();
        step();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_read_en", 32'(inst_mem_read_enable), 32'd0);
        chk("async_reset_kick", 32'(instruction_kick_up), 32'd0);
        chk("async_reset_addr", inst_mem_read_addr, 32'h0);
        step();
        chk("held_reset_addr", inst_mem_read_addr, 32'h0);
        push_exp(32'h0, -1);
        reset = 1'b0;
        wait_issue();
        step(); step();
        drive_br(1'b1); drive_z(1'b1);
        step(); clear_in();
        stall_check("no_stale_imme_stall", 6);
        push_exp(32'h20, -1);
        drive_imm(32'h20);
        step(); clear_in();
        wait_issue();
        step(); step();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the multi-cycle, handshake-driven RISC-V core.
- Holds the PC and issues one instruction-memory read per instruction.
- Signals downstream when the fetched instruction is available.
- Waits for branch resolution (controller branch flag, ALU zero flag, immediate), each qualified by a one-cycle "kick_up" strobe, before computing the next PC and fetching again.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Controller_branch  input  1  current instruction is a branch; valid only while Controller_branch_kick_up=1.
- Controller_branch_kick_up  input  1  one-cycle strobe qualifying Controller_branch.
- ALU_Zero  input  1  ALU zero flag (branch condition); valid only while ALU_Zero_kick_up=1.
- ALU_Zero_kick_up  input  1  one-cycle strobe qualifying ALU_Zero.
- imme  input  32  sign-extended branch offset in bytes; valid only while imme_kick_up=1.
- imme_kick_up  input  1  one-cycle strobe qualifying imme.
- instruction_kick_up  output  1  one-cycle strobe: instruction memory data for the current PC is valid.
- inst_mem_read_enable  output  1  instruction memory read request; high for exactly one cycle per fetch.
- inst_mem_read_addr  output  32  byte address of the fetch; equals the PC.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate):
  - PC=RESET_PC; state=IDLE.
  - inst_mem_read_enable=0; instruction_kick_up=0; inst_mem_read_addr=RESET_PC.
  - All latched handshake flags and values cleared.
- State machine:
  - IDLE: first rising edge after reset release -> ISSUE.
  - ISSUE: inst_mem_read_enable=1, inst_mem_read_addr=PC, for exactly one cycle -> DELIVER.
  - DELIVER: inst_mem_read_enable=0, instruction_kick_up=1 for one cycle; memory has 1-cycle read latency -> RESOLVE.
  - RESOLVE: both outputs 0; stays here until the decision is complete.
- Handshake capture:
  - In any non-reset state, each *_kick_up=1 latches its data (branch, zero, imme) and sets a sticky "have" flag.
  - A repeated strobe before resolution overwrites the stored value.
  - Effective flag/value in a cycle = current strobe/data if the strobe is high, otherwise the latched copy.
- Decision, evaluated in RESOLVE each cycle:
  - No effective branch flag: wait.
  - Branch flag present and branch=0: next PC = PC+PC_STEP. The zero flag and immediate are not required.
  - Branch flag present and branch=1: wait until both the zero flag and the immediate are present. Then next PC = PC+imme if zero=1, else PC+PC_STEP.
- On the resolving edge:
  - PC is updated; all have-flags are cleared; state -> ISSUE.
  - Strobes arriving on that same cycle are consumed by this decision and do not carry over.
- Arithmetic:
  - 32-bit modulo 2^32; wrap-around permitted, e.g. 32'hFFFF_FFFC+4 = 0.
  - Negative imme is two's complement.
  - No alignment check.
- Stall: no strobes -> remains in RESOLVE indefinitely; outputs held at 0; PC unchanged.
- Minimum fetch period is 3 cycles (ISSUE, DELIVER, RESOLVE with resolution in the first RESOLVE cycle).
- Reset mid-operation in any state aborts the instruction, discards latched data and returns to IDLE with PC=RESET_PC.

Test Plan:
- All inputs 0, reset pulse then release:
  - Edge 1 -> read_enable=1, addr=0.
  - Edge 2 -> instruction_kick_up=1.
  - Thereafter both outputs 0 forever; addr stays 0.
- Non-branch sequence:
  - In each RESOLVE cycle, pulse Controller_branch_kick_up with Controller_branch=0.
  - Fetch addresses 0, 4, 8, 12 with a 3-cycle period.
- Taken branch:
  - PC=8; pulse branch=1 in one cycle, then imme=32'h10 two cycles later, then ALU_Zero=1.
  - Next fetch addr = 32'h18, issued only after the last strobe.
- Not-taken branch and negative offset:
  - At PC=8, branch=1, zero=0, imme=32'h10 -> next fetch 12.
  - At PC=32'h20, branch=1, zero=1, imme=32'hFFFF_FFF0 -> next fetch 32'h10.
- Early and simultaneous strobes:
  - All three strobes fire in the DELIVER cycle (branch=1, zero=1, imme=4) at PC=0 -> next fetch 4, one cycle into RESOLVE.
  - Strobes arriving in the same cycle the PC updates are not reused for the next instruction.
- Wrap-around and reset:
  - PC=32'hFFFF_FFFC, non-branch -> next addr 0.
  - Assert reset while in RESOLVE with latched imme -> outputs 0 immediately, addr=RESET_PC, and no stale data after restart.
